// File: rtl/block_seq.sv
// Purpose : fetch/latch/execute sequencer driving a 1-bit ALU and data memory.
// Latency : 3 cycles per instruction (FETCH, LATCH, EXEC); start to first EXEC = 3 cycles.
// Backpressure: none; start is ignored while busy, stop is acted on only in EXEC.
//
// Ports:
//   clk, rst       clock and synchronous active-low reset
//   start, stop    run request (IDLE/HALT only), halt request (EXEC only)
//   pc_addr        program memory address (ROM is registered: instr_in lags by one cycle)
//   instr_in       program word {opcode, operand}
//   zero_flag      ALU zero flag, sampled during EXEC of JZ/JNZ
//   alu_op, wr_cr  ALU operation select and current-result write enable
//   dm_addr        data memory address (instruction operand)
//   dm_wr_en       data memory write strobe (data comes from the ALU)
//   busy, halted   status: executing / stopped in HALT
module block_seq #(
  parameter int ADDR_WIDTH = 4,
  parameter int OP_WIDTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  output logic [ADDR_WIDTH-1:0]        pc_addr,
  input  logic [OP_WIDTH+ADDR_WIDTH-1:0] instr_in,
  input  logic                         zero_flag,
  output logic [OP_WIDTH-1:0]          alu_op,
  output logic                         wr_cr,
  output logic [ADDR_WIDTH-1:0]        dm_addr,
  output logic                         dm_wr_en,
  output logic                         busy,
  output logic                         halted
);

  localparam logic [OP_WIDTH-1:0] OP_NOP  = OP_WIDTH'(4'h0);
  localparam logic [OP_WIDTH-1:0] OP_LD   = OP_WIDTH'(4'h1);
  localparam logic [OP_WIDTH-1:0] OP_LDN  = OP_WIDTH'(4'h2);
  localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(4'h3);
  localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(4'h4);
  localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(4'h5);
  localparam logic [OP_WIDTH-1:0] OP_NOT  = OP_WIDTH'(4'h6);
  localparam logic [OP_WIDTH-1:0] OP_ST   = OP_WIDTH'(4'h7);
  localparam logic [OP_WIDTH-1:0] OP_STN  = OP_WIDTH'(4'h8);
  localparam logic [OP_WIDTH-1:0] OP_JMP  = OP_WIDTH'(4'h9);
  localparam logic [OP_WIDTH-1:0] OP_JZ   = OP_WIDTH'(4'hA);
  localparam logic [OP_WIDTH-1:0] OP_JNZ  = OP_WIDTH'(4'hB);
  localparam logic [OP_WIDTH-1:0] OP_HALT = OP_WIDTH'(4'hF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_EXEC,
    S_HALT
  } state_t;

  state_t                        state, state_nxt;
  logic [ADDR_WIDTH-1:0]         pc, pc_nxt;
  logic [OP_WIDTH+ADDR_WIDTH-1:0] ir, ir_nxt;
  logic [OP_WIDTH-1:0]           opcode;
  logic [ADDR_WIDTH-1:0]         operand;
  logic                          jump_taken;

  assign opcode  = ir[OP_WIDTH+ADDR_WIDTH-1 -: OP_WIDTH];
  assign operand = ir[ADDR_WIDTH-1:0];

  assign pc_addr = pc;
  assign dm_addr = operand;
  assign busy    = (state == S_FETCH) || (state == S_LATCH) || (state == S_EXEC);
  assign halted  = (state == S_HALT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ir_nxt     = ir;
    alu_op     = OP_ST;   // ST leaves the ALU result register untouched
    wr_cr      = 1'b0;
    dm_wr_en   = 1'b0;
    jump_taken = 1'b0;

    case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_nxt = S_FETCH;
          pc_nxt    = '0;
        end
      end

      S_FETCH: state_nxt = S_LATCH;

      S_LATCH: begin
        // ROM output for pc is valid now, one cycle after FETCH presented it
        ir_nxt    = instr_in;
        state_nxt = S_EXEC;
      end

      S_EXEC: begin
        case (opcode)
          OP_LD, OP_LDN, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
            alu_op = opcode;
            wr_cr  = 1'b1;
          end
          OP_ST, OP_STN: begin
            alu_op   = opcode;
            dm_wr_en = 1'b1;
          end
          OP_JMP:  jump_taken = 1'b1;
          OP_JZ:   jump_taken = zero_flag;
          OP_JNZ:  jump_taken = !zero_flag;
          default: jump_taken = 1'b0;   // NOP, HALT and unused opcodes
        endcase

        pc_nxt = jump_taken ? operand : pc + ADDR_WIDTH'(1);

        if (opcode == OP_HALT) begin
          // HALT leaves pc pointing at itself
          state_nxt = S_HALT;
          pc_nxt    = pc;
        end else if (stop) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_FETCH;
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    // A reset arriving mid-EXEC must not let a write strobe escape
    if (!rst) begin
      alu_op   = OP_ST;
      wr_cr    = 1'b0;
      dm_wr_en = 1'b0;
    end
  end

  // NOP has no action of its own; keep the name referenced for readers
  logic unused_nop;
  assign unused_nop = (opcode == OP_NOP);

endmodule

// File: tb/tb_block_seq.sv
module tb_block_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [3:0] pc_addr;
  logic [7:0] instr_in;
  logic       zero_flag;
  logic [3:0] alu_op;
  logic       wr_cr;
  logic [3:0] dm_addr;
  logic       dm_wr_en;
  logic       busy;
  logic       halted;

  int checks = 0;
  int errors = 0;

  logic [7:0] rom [16];

  block_seq #(.ADDR_WIDTH(4), .OP_WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .pc_addr  (pc_addr),
    .instr_in (instr_in),
    .zero_flag(zero_flag),
    .alu_op   (alu_op),
    .wr_cr    (wr_cr),
    .dm_addr  (dm_addr),
    .dm_wr_en (dm_wr_en),
    .busy     (busy),
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered program ROM: word appears one cycle after its address
  always @(posedge clk) instr_in <= rom[pc_addr];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Runs {word @0, HALT @1, HALT @6}; checks the pc reached after EXEC.
  task automatic run_jump(input string tag, input logic zf, input logic [7:0] word,
                          input logic [31:0] exp_pc);
    clear_rom();
    rom[0] = word;
    rom[1] = 8'hF0;
    rom[6] = 8'hF0;
    zero_flag = zf;
    pulse_start();                 // cycle 1 FETCH
    step();                        // cycle 2 LATCH
    step();                        // cycle 3 EXEC
    chk({tag, " alu_op in exec"}, 32'(alu_op), 32'h7);
    step();                        // cycle 4 FETCH of next instruction
    chk({tag, " next pc_addr"}, 32'(pc_addr), exp_pc);
    step(); step(); step();        // HALT executes, cycle 7 in HALT
    chk({tag, " halted"}, 32'(halted), 1);
    chk({tag, " halt pc"}, 32'(pc_addr), exp_pc);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; zero_flag = 1'b0;
    clear_rom();

    // Reset state
    step(); step();
    chk("rst busy", 32'(busy), 0);
    chk("rst halted", 32'(halted), 0);
    chk("rst wr_cr", 32'(wr_cr), 0);
    chk("rst dm_wr_en", 32'(dm_wr_en), 0);
    chk("rst alu_op", 32'(alu_op), 32'h7);
    chk("rst pc_addr", 32'(pc_addr), 0);
    chk("rst dm_addr", 32'(dm_addr), 0);
    rst = 1'b1;
    step();
    chk("idle holds without start", 32'(busy), 0);

    // Program {LD 3, AND 4, ST 5, HALT}
    rom[0] = 8'h13; rom[1] = 8'h34; rom[2] = 8'h75; rom[3] = 8'hF0;
    pulse_start();
    for (int c = 1; c <= 12; c++) begin
      chk($sformatf("prog wr_cr c%0d", c), 32'(wr_cr), 32'(c == 3 || c == 6));
      chk($sformatf("prog dm_wr_en c%0d", c), 32'(dm_wr_en), 32'(c == 9));
      chk($sformatf("prog busy c%0d", c), 32'(busy), 1);
      if (c == 1) chk("prog first pc_addr", 32'(pc_addr), 0);
      if (c == 3) begin
        chk("prog LD alu_op", 32'(alu_op), 32'h1);
        chk("prog LD dm_addr", 32'(dm_addr), 32'h3);
      end
      if (c == 6) chk("prog AND alu_op", 32'(alu_op), 32'h3);
      if (c == 9) begin
        chk("prog ST alu_op", 32'(alu_op), 32'h7);
        chk("prog ST dm_addr", 32'(dm_addr), 32'h5);
      end
      if (c == 5) chk("prog LATCH alu_op", 32'(alu_op), 32'h7);
      step();
    end
    chk("prog halted c13", 32'(halted), 1);
    chk("prog busy c13", 32'(busy), 0);
    chk("prog halt pc", 32'(pc_addr), 32'h3);
    chk("prog wr_cr c13", 32'(wr_cr), 0);

    // Conditional and unconditional jumps
    run_jump("jz taken", 1'b1, 8'hA6, 32'h6);
    run_jump("jz not taken", 1'b0, 8'hA6, 32'h1);
    run_jump("jnz taken", 1'b0, 8'hB6, 32'h6);
    run_jump("jnz not taken", 1'b1, 8'hB6, 32'h1);
    run_jump("jmp", 1'b1, 8'h96, 32'h6);

    // 16 NOPs: pc wraps 15 -> 0, busy stays high
    clear_rom();
    pulse_start();
    for (int c = 1; c <= 49; c++) begin
      chk($sformatf("nop busy c%0d", c), 32'(busy), 1);
      chk($sformatf("nop writes c%0d", c), 32'({wr_cr, dm_wr_en}), 0);
      if ((c - 1) % 3 == 0)
        chk($sformatf("nop pc_addr c%0d", c), 32'(pc_addr), 32'(((c - 1) / 3) % 16));
      if (c < 49) step();
    end
    // stop pulsed only in FETCH is not remembered
    stop = 1'b1;
    step();                        // LATCH
    stop = 1'b0;
    step();                        // EXEC
    step();                        // FETCH pc=1
    chk("fetch stop busy", 32'(busy), 1);
    chk("fetch stop halted", 32'(halted), 0);
    chk("fetch stop pc", 32'(pc_addr), 32'h1);
    step(); step();                // EXEC of NOP @1
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("exec stop halted", 32'(halted), 1);
    chk("exec stop pc advanced", 32'(pc_addr), 32'h2);

    // stop held through LD: the write pulse still happens, then HALT
    clear_rom();
    rom[0] = 8'h19;
    stop = 1'b1;
    pulse_start();                 // cycle 1 FETCH
    step();                        // cycle 2 LATCH
    chk("ld stop busy c2", 32'(busy), 1);
    step();                        // cycle 3 EXEC
    chk("ld stop wr_cr", 32'(wr_cr), 1);
    chk("ld stop alu_op", 32'(alu_op), 32'h1);
    chk("ld stop dm_addr", 32'(dm_addr), 32'h9);
    step();
    stop = 1'b0;
    chk("ld stop halted", 32'(halted), 1);
    chk("ld stop wr_cr after", 32'(wr_cr), 0);
    chk("ld stop pc", 32'(pc_addr), 32'h1);

    // Unused opcodes act as NOP; start while busy is ignored
    clear_rom();
    rom[0] = 8'hD7; rom[1] = 8'hC2; rom[2] = 8'hF0;
    pulse_start();
    step(); step();                // cycle 3 EXEC of 0xD
    chk("op D writes", 32'({wr_cr, dm_wr_en}), 0);
    chk("op D dm_addr", 32'(dm_addr), 32'h7);
    step();                        // cycle 4 FETCH pc=1
    chk("op D pc advance", 32'(pc_addr), 32'h1);
    start = 1'b1;
    step(); step();                // cycle 6 EXEC of 0xC
    chk("op C writes", 32'({wr_cr, dm_wr_en}), 0);
    step();                        // cycle 7 FETCH
    start = 1'b0;
    chk("busy start pc", 32'(pc_addr), 32'h2);
    chk("busy start busy", 32'(busy), 1);
    step(); step(); step();
    chk("busy start halted", 32'(halted), 1);
    chk("busy start halt pc", 32'(pc_addr), 32'h2);

    // Reset during EXEC of ST aborts the store
    clear_rom();
    rom[0] = 8'h75;
    pulse_start();
    step(); step();                // cycle 3 EXEC
    chk("st dm_wr_en", 32'(dm_wr_en), 1);
    chk("st dm_addr", 32'(dm_addr), 32'h5);
    rst = 1'b0;
    start = 1'b1;                  // reset wins over start
    #1;
    chk("rst cycle dm_wr_en", 32'(dm_wr_en), 0);
    chk("rst cycle wr_cr", 32'(wr_cr), 0);
    step();
    chk("mid rst busy", 32'(busy), 0);
    chk("mid rst halted", 32'(halted), 0);
    chk("mid rst dm_wr_en", 32'(dm_wr_en), 0);
    chk("mid rst wr_cr", 32'(wr_cr), 0);
    chk("mid rst alu_op", 32'(alu_op), 32'h7);
    chk("mid rst pc_addr", 32'(pc_addr), 0);
    chk("mid rst dm_addr", 32'(dm_addr), 0);
    rst = 1'b1;
    start = 1'b0;
    step();
    chk("post rst idle", 32'(busy), 0);
    chk("post rst dm_wr_en", 32'(dm_wr_en), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_seq.md
BLOCK_SEQ -- requirements
Module: block_seq

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, setting the width of the program counter, the instruction operand and the data-memory address.
REQ-002 The block SHALL have parameter OP_WIDTH, default 4, setting the width of the opcode field and of alu_op.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: run request, honoured only in IDLE or HALT.
REQ-006 The block SHALL have port stop, input, 1 bit: halt request, honoured at the end of an EXEC cycle.
REQ-007 The block SHALL have port pc_addr, output, ADDR_WIDTH bits: program memory address.
REQ-008 The block SHALL have port instr_in, input, OP_WIDTH+ADDR_WIDTH bits: program word, {opcode, operand}, valid one cycle after pc_addr (registered ROM).
REQ-009 The block SHALL have port zero_flag, input, 1 bit: ALU zero flag.
REQ-010 The block SHALL have port alu_op, output, OP_WIDTH bits: ALU operation select.
REQ-011 The block SHALL have port wr_cr, output, 1 bit: ALU current-result write enable.
REQ-012 The block SHALL have port dm_addr, output, ADDR_WIDTH bits: data memory address.
REQ-013 The block SHALL have port dm_wr_en, output, 1 bit: data memory write strobe; the write data is the ALU output.
REQ-014 The block SHALL have port busy, output, 1 bit: high in FETCH, LATCH and EXEC.
REQ-015 The block SHALL have port halted, output, 1 bit: high in HALT.

Function
REQ-016 Opcodes SHALL be: NOP=0x0, LD=0x1, LDN=0x2, AND=0x3, OR=0x4, XOR=0x5, NOT=0x6, ST=0x7, STN=0x8, JMP=0x9, JZ=0xA, JNZ=0xB, HALT=0xF; 0xC-0xE SHALL execute as NOP.
REQ-017 The FSM SHALL have states IDLE, FETCH, LATCH, EXEC and HALT, one cycle each except IDLE and HALT; every instruction SHALL take exactly 3 cycles.
REQ-018 IDLE/HALT + start=1 SHALL go to FETCH with pc=0; otherwise the FSM SHALL stay in IDLE/HALT.
REQ-019 In FETCH, pc_addr SHALL equal pc, and the FSM SHALL go to LATCH.
REQ-020 In LATCH, ir SHALL be loaded from instr_in, and the FSM SHALL go to EXEC.
REQ-021 In EXEC, dm_addr SHALL equal ir operand; for LD, LDN, AND, OR, XOR and NOT, alu_op SHALL equal the opcode and wr_cr SHALL be 1 for this cycle only.
REQ-022 In EXEC, for ST and STN, alu_op SHALL equal the opcode and dm_wr_en SHALL be 1 for this cycle only; wr_cr SHALL stay 0.
REQ-023 In EXEC, for JZ and JNZ, alu_op SHALL be ST, and zero_flag SHALL be sampled in this cycle; the jump SHALL be taken when zero_flag=1 for JZ and when zero_flag=0 for JNZ.
REQ-024 pc update at the end of EXEC SHALL be: JMP or a taken conditional jump -> operand; otherwise pc+1, wrapping from 2^ADDR_WIDTH-1 to 0.
REQ-025 On an EXEC HALT opcode, the FSM SHALL go to HALT with pc not advanced; otherwise, if stop=1 in EXEC, it SHALL go to HALT with pc already updated; otherwise it SHALL go to FETCH.
REQ-026 Outside EXEC, alu_op SHALL be ST (non-destructive), and wr_cr and dm_wr_en SHALL be 0.
REQ-027 start while busy SHALL be ignored; stop outside EXEC SHALL have no effect and SHALL NOT be remembered.
REQ-028 An EXEC cycle where stop=1 and the instruction is a write SHALL still complete its wr_cr/dm_wr_en pulse before HALT.

Reset
REQ-029 When rst=0 at a rising edge, the block SHALL enter IDLE with pc=0 and ir=0, and SHALL hold busy=0, halted=0, wr_cr=0, dm_wr_en=0, alu_op=ST, pc_addr=0 and dm_addr=0.
REQ-030 Reset asserted mid-instruction SHALL abort it; no wr_cr or dm_wr_en pulse SHALL occur in the reset cycle or the cycle after.
REQ-031 Reset SHALL have priority over start and stop.

Verification
REQ-032 A bench SHALL check: ROM {LD 3, AND 4, ST 5, HALT}, start pulse -> wr_cr pulses at cycles 3 and 6 after start, dm_wr_en with dm_addr=5 at cycle 9, halted=1 at cycle 13, pc=3.
REQ-033 A bench SHALL check: JZ 6 with zero_flag=1 -> next pc_addr=6; the same with zero_flag=0 -> next pc_addr=pc+1.
REQ-034 A bench SHALL check: 16 NOPs from pc=0 -> pc_addr wraps 15 -> 0 and busy stays 1.
REQ-035 A bench SHALL check: stop held high during LD in EXEC -> wr_cr pulse occurs, then halted=1 next cycle; stop pulsed only in FETCH -> no halt.
REQ-036 A bench SHALL check: rst=0 during EXEC of ST -> dm_wr_en=0 after the edge, IDLE entered, and all outputs at their reset values.
REQ-037 A bench SHALL check: start during busy -> no pc change; opcode 0xD -> behaves as NOP, with no write pulses.
